icache_fetcher: RTL
===================

// Module: icache_fetcher
// PURPOSE
//  Parametrised instruction fetcher with set-associative I-cache and line refill via the memory controller.
//  Supplies one 32-bit instruction per cycle to the issuer; honours issuer stall and branch redirect.
//  Also honours whole-cache invalidate (fence.i). Sits between the issuer and the memory controller.
// PARAMETERS
//  RESET_PC    32'h0  pc loaded at reset
//  LINE_BYTES  16     cache line size in bytes; power of 2, >=4
//  SETS        16     number of sets; power of 2, >=2
//  WAYS        2      associativity; 1 or 2 (2 => 1 LRU bit per set)
// PORTS
//  clk                    in   1            clock, rising edge
//  rst                    in   1            asynchronous, active-high reset
//  rdy                    in   1            global enable; when low, no state changes
//  stall                  in   1            issuer cannot accept this cycle
//  redirect_valid         in   1            branch/jump redirect; pc <= redirect_pc
//  redirect_pc            in   32           redirect target
//  invalidate             in   1            clear all valid bits (fence.i)
//  valid_to_mem_ctrler    out  1            refill request
//  addr_to_mem_ctrler     out  32           line-aligned refill address
//  ready_from_mem_ctrler  in   1            1-cycle pulse: line data valid
//  cache_line_from_mem_ctrler in 8*LINE_BYTES  refill data, byte 0 in bits [7:0]
//  ready_to_issuer        out  1            inst_to_issuer/pc_to_issuer valid
//  inst_to_issuer         out  32           instruction at pc
//  pc_to_issuer           out  32           address of inst_to_issuer
// BEHAVIOUR
//  Reset (async): pc=RESET_PC; state=IDLE; all valid and LRU bits 0.
//   Reset also sets valid_to_mem_ctrler=0, addr_to_mem_ctrler=0, drop=0. Tags/data are not reset.
//  Address split: offset=pc[log2(LINE_BYTES)-1:0], index=next log2(SETS) bits, tag=rest; pc[1:0] ignored.
//  hit = any way valid with matching tag at index (combinational on pc).
//  ready_to_issuer = hit & !redirect_valid & !invalidate. inst = line[offset*8 +: 32]. Outputs are 0 when not ready.
//  Advance: ready_to_issuer & !stall & rdy => pc<=pc+4; the hit way becomes MRU.
//  Redirect: redirect_valid & rdy => pc<=redirect_pc. It has priority over advance, in any state.
//  States:
//   IDLE: !hit & !invalidate => latch line-aligned pc into addr_to_mem_ctrler, valid<=1, go to REFILL.
//    The request goes out one cycle after the miss is seen.
//   REFILL: valid_to_mem_ctrler and addr held constant until ready_from_mem_ctrler.
//    Data is never cancelled toward the memory controller.
//    On ready: if !drop, write tag/line/valid into victim way of the set given by latched addr.
//    In that case the victim way becomes MRU. Then valid<=0, drop<=0, state IDLE.
//  Victim: way 0 if invalid, else way 1 if invalid, else the LRU way. WAYS=1: always way 0.
//  Redirect during REFILL: refill continues and fills the latched line (data correct for its address).
//   After returning to IDLE, a miss on the new pc starts a new request.
//  invalidate: all valid bits cleared at the edge. In REFILL it sets drop, so the in-flight line is discarded.
//   If invalidate and ready_from_mem_ctrler coincide, the line is dropped.
//  Refill write and same-cycle hit: the write takes effect next cycle; the hit is evaluated on old contents.
//  Hit-under-refill: allowed only if the line is already present. The issuer is not served from the incoming line until it is written.
//  pc wrap: pc+4 wraps modulo 2^32.
//  rdy=0: all registers hold, including valid_to_mem_ctrler.
// STRUCTURE
//  config.v shared defines: ADDR_TYPE, INST_TYPE, REG_TYPE, reset-pc default.
//   Also add line/tag/index width macros derived from the parameters, and the IDLE/REFILL state encodings.
//  Sub-module icache_way: one way's tag/data/valid arrays.
//   Read port by index with tag compare -> hit, line. Write port for refill. Bulk valid clear.
//   Instantiated WAYS times. The top holds the pc, the FSM, the LRU bits and the victim select.
// TESTING
//  Cold start, RESET_PC=0: req addr 0x0 one cycle after reset release.
//   Mem returns line after 5 cycles -> ready_to_issuer next cycle; inst = bytes 0..3, pc 0,4,8,0xC consecutive.
//  Stall held 3 cycles with hit -> pc_to_issuer and inst stable, no mem request.
//  2-way conflict: fetch 0x000, 0x100, 0x200 (same set, SETS=16, LINE=16).
//   -> 0x200 evicts 0x000 (LRU); refetch 0x100 hits, 0x000 misses.
//  Redirect to 0x40 during REFILL of 0x10 -> line 0x10 is still filled.
//   A new req for 0x40 follows; the first instruction issued is at pc 0x40.
//  invalidate during REFILL -> returned line dropped; the next cycle misses and re-requests the same address.
//  Async rst asserted mid-REFILL -> valid_to_mem_ctrler=0 immediately; after release, pc=RESET_PC and a cold miss occurs.

Source files
------------

// File: rtl/icache_fetcher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_fetcher_pkg
// Description : Shared types, widths and helpers for the instruction fetcher:
//               address/instruction types, reset-pc default, refill FSM
//               state encoding and a line-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_fetcher_pkg;

    localparam int unsigned c_ADDR_W           = 32;
    localparam int unsigned c_INST_W           = 32;
    localparam int unsigned c_REG_W            = 32;
    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [c_ADDR_W-1:0] addr_t;
    typedef logic [c_INST_W-1:0] inst_t;
    typedef logic [c_REG_W-1:0]  reg_t;

    // Refill controller states
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_t;

    // Clear the byte-offset bits of an address (line_bytes is a power of 2)
    function automatic addr_t line_base(input addr_t addr, input int unsigned line_bytes);
        return addr & ~(addr_t'(line_bytes) - addr_t'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_fetcher_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_fetcher_if
// Description : Issuer-side and memory-controller-side signals of the fetcher.
//               master : the fetcher (drives refill request and issue outputs)
//               slave  : the environment (issuer + memory controller)
//               Issuer   : stall, redirect_valid/pc, invalidate ->
//                          ready_to_issuer, inst_to_issuer, pc_to_issuer
//               Mem ctrl : valid/addr_to_mem_ctrler ->
//                          ready_from_mem_ctrler, cache_line_from_mem_ctrler
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_fetcher_if #(
    parameter int unsigned LINE_BYTES = 16
);
    import icache_fetcher_pkg::*;

    logic                    stall;
    logic                    redirect_valid;
    addr_t                   redirect_pc;
    logic                    invalidate;

    logic                    valid_to_mem_ctrler;
    addr_t                   addr_to_mem_ctrler;
    logic                    ready_from_mem_ctrler;
    logic [8*LINE_BYTES-1:0] cache_line_from_mem_ctrler;

    logic                    ready_to_issuer;
    inst_t                   inst_to_issuer;
    addr_t                   pc_to_issuer;

    modport master (
        input  stall, redirect_valid, redirect_pc, invalidate,
        input  ready_from_mem_ctrler, cache_line_from_mem_ctrler,
        output valid_to_mem_ctrler, addr_to_mem_ctrler,
        output ready_to_issuer, inst_to_issuer, pc_to_issuer
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, invalidate,
        output ready_from_mem_ctrler, cache_line_from_mem_ctrler,
        input  valid_to_mem_ctrler, addr_to_mem_ctrler,
        input  ready_to_issuer, inst_to_issuer, pc_to_issuer
    );

endinterface
`default_nettype wire

// File: rtl/icache_fetcher_way.sv
`default_nettype none
// ============================================================================
// Module      : icache_fetcher_way
// Description : One way of the instruction cache: tag, line data and valid
//               arrays. Combinational read by index with tag compare, a
//               second valid read port for victim selection, one write port
//               for refills and a bulk valid clear.
//   clk, rst            : clock, asynchronous active-high reset (valid only)
//   i_rd_index/i_rd_tag : lookup -> o_hit, o_line
//   i_vic_index         : victim probe -> o_vic_valid
//   i_we, i_wr_*        : refill write (tag, line, sets valid)
//   i_clear             : clear every valid bit
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fetcher_way #(
    parameter int unsigned SETS   = 16,
    parameter int unsigned TAG_W  = 24,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned IDX_W  = $clog2(SETS)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [IDX_W-1:0]  i_rd_index,
    input  wire logic [TAG_W-1:0]  i_rd_tag,
    output logic                   o_hit,
    output logic [LINE_W-1:0]      o_line,
    input  wire logic [IDX_W-1:0]  i_vic_index,
    output logic                   o_vic_valid,
    input  wire logic              i_we,
    input  wire logic [IDX_W-1:0]  i_wr_index,
    input  wire logic [TAG_W-1:0]  i_wr_tag,
    input  wire logic [LINE_W-1:0] i_wr_line,
    input  wire logic              i_clear
);

    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    // Clear wins over a same-cycle write; the top never requests both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_clear) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tags and data need no reset: they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_line;
        end
    end

    assign o_hit       = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
    assign o_line      = r_data[i_rd_index];
    assign o_vic_valid = r_valid[i_vic_index];

endmodule
`default_nettype wire

// File: rtl/icache_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : icache_fetcher
// Description : Instruction fetcher with a set-associative I-cache. Supplies
//               one 32-bit instruction per cycle to the issuer, honours stall,
//               branch redirect and whole-cache invalidate, and refills missing
//               lines through the memory controller one line at a time.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   rdy  : global enable; when low no state changes
//   bus  : icache_fetcher_if.master (issuer + memory controller signals)
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fetcher
    import icache_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = c_RESET_PC_DEFAULT,
    parameter int unsigned LINE_BYTES = 16,
    parameter int unsigned SETS       = 16,
    parameter int unsigned WAYS       = 2
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         rdy,
    icache_fetcher_if.master  bus
);

    localparam int unsigned c_OFF_W  = $clog2(LINE_BYTES);
    localparam int unsigned c_IDX_W  = $clog2(SETS);
    localparam int unsigned c_TAG_W  = c_ADDR_W - c_OFF_W - c_IDX_W;
    localparam int unsigned c_LINE_W = 8 * LINE_BYTES;

    addr_t               r_pc;
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_req_valid;
    logic                w_req_valid_nxt;
    addr_t               r_req_addr;
    addr_t               w_req_addr_nxt;
    logic                r_drop;
    logic                w_drop_nxt;
    logic                w_refill_we;
    logic                w_fill;

    logic [c_IDX_W-1:0]  w_pc_index;
    logic [c_TAG_W-1:0]  w_pc_tag;
    logic [c_OFF_W-1:0]  w_word_off;
    logic [c_IDX_W-1:0]  w_req_index;
    logic [c_TAG_W-1:0]  w_req_tag;

    logic [WAYS-1:0]     w_way_hit;
    logic [WAYS-1:0]     w_way_vic_valid;
    logic [c_LINE_W-1:0] w_way_line [WAYS];
    logic [c_LINE_W-1:0] w_sel_line;
    logic                w_hit;
    logic                w_hit_way;
    logic                w_victim;
    logic                w_ready;
    logic                w_advance;

    assign w_pc_index  = r_pc[c_OFF_W +: c_IDX_W];
    assign w_pc_tag    = r_pc[c_ADDR_W-1 -: c_TAG_W];
    // pc[1:0] does not select a byte: instructions are read word-aligned.
    assign w_word_off  = r_pc[c_OFF_W-1:0] & ~c_OFF_W'(3);
    assign w_req_index = r_req_addr[c_OFF_W +: c_IDX_W];
    assign w_req_tag   = r_req_addr[c_ADDR_W-1 -: c_TAG_W];

    // Refill writes only land when the enable is up.
    assign w_fill = w_refill_we & rdy;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        icache_fetcher_way #(
            .SETS   (SETS),
            .TAG_W  (c_TAG_W),
            .LINE_W (c_LINE_W)
        ) u_way (
            .clk         (clk),
            .rst         (rst),
            .i_rd_index  (w_pc_index),
            .i_rd_tag    (w_pc_tag),
            .o_hit       (w_way_hit[g]),
            .o_line      (w_way_line[g]),
            .i_vic_index (w_req_index),
            .o_vic_valid (w_way_vic_valid[g]),
            .i_we        (w_fill && (w_victim == 1'(g))),
            .i_wr_index  (w_req_index),
            .i_wr_tag    (w_req_tag),
            .i_wr_line   (bus.cache_line_from_mem_ctrler),
            .i_clear     (bus.invalidate & rdy)
        );
    end

    if (WAYS == 2) begin : g_lru2
        // One bit per set naming the way to evict next (the non-MRU way).
        logic [SETS-1:0] r_lru;

        assign w_hit_way = w_way_hit[1];
        assign w_victim  = !w_way_vic_valid[0] ? 1'b0 :
                           !w_way_vic_valid[1] ? 1'b1 : r_lru[w_req_index];

        // A refill into the same set in the same cycle overrides the
        // advance update: the freshly filled way is the MRU one.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_lru <= '0;
            end else if (rdy) begin
                if (w_advance) begin
                    r_lru[w_pc_index] <= ~w_hit_way;
                end
                if (w_refill_we) begin
                    r_lru[w_req_index] <= ~w_victim;
                end
            end
        end
    end else begin : g_lru1
        assign w_hit_way = 1'b0;
        assign w_victim  = 1'b0;
    end

    assign w_hit      = |w_way_hit;
    assign w_sel_line = w_hit_way ? w_way_line[WAYS-1] : w_way_line[0];
    assign w_ready    = w_hit & ~bus.redirect_valid & ~bus.invalidate;
    assign w_advance  = w_ready & ~bus.stall;

    assign bus.ready_to_issuer     = w_ready;
    assign bus.inst_to_issuer      = w_ready ? w_sel_line[{w_word_off, 3'b000} +: c_INST_W] : '0;
    assign bus.pc_to_issuer        = w_ready ? r_pc : '0;
    assign bus.valid_to_mem_ctrler = r_req_valid;
    assign bus.addr_to_mem_ctrler  = r_req_addr;

    // Refill controller: one outstanding line request at a time. A request,
    // once issued, always completes; invalidate only marks its data as
    // stale so that it is not written into the cache.
    always_comb begin
        w_state_nxt     = r_state;
        w_req_valid_nxt = r_req_valid;
        w_req_addr_nxt  = r_req_addr;
        w_drop_nxt      = r_drop;
        w_refill_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_hit && !bus.invalidate) begin
                    w_state_nxt     = ST_REFILL;
                    w_req_valid_nxt = 1'b1;
                    w_req_addr_nxt  = line_base(r_pc, LINE_BYTES);
                end
            end
            ST_REFILL: begin
                if (bus.invalidate) begin
                    w_drop_nxt = 1'b1;
                end
                if (bus.ready_from_mem_ctrler) begin
                    w_refill_we     = !r_drop && !bus.invalidate;
                    w_req_valid_nxt = 1'b0;
                    w_drop_nxt      = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_drop      <= 1'b0;
            r_pc        <= RESET_PC;
        end else if (rdy) begin
            r_state     <= w_state_nxt;
            r_req_valid <= w_req_valid_nxt;
            r_req_addr  <= w_req_addr_nxt;
            r_drop      <= w_drop_nxt;
            if (bus.redirect_valid) begin
                r_pc <= bus.redirect_pc;
            end else if (w_advance) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

endmodule
`default_nettype wire
